// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath sequencer: op encodings,
// FSM state type, datapath width and the signed-overflow helper.
package calc_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int MUL_ITERS  = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } calc_state_t;

    // Two's-complement overflow: operands agree in sign, sum sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/carselec.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry-in
// cases and selecting on the carry rippled from the block below.
module carselec (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [4:0] blk_c;

    assign blk_c[0] = c_in;

    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] s0;
        logic [4:0] s1;

        assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
        assign sum[4*g +: 4] = blk_c[g] ? s1[3:0] : s0[3:0];
        assign blk_c[g+1]    = blk_c[g] ? s1[4]   : s0[4];
    end

    assign c_out = blk_c[4];

endmodule

// File: rtl/calc_alu_seq.sv
// Operand sequencer and result register feeding the shared carselec adder.
// Define CALC_MUL_EN to build the 16-iteration shift-add MUL; otherwise op 10 reports err.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf,
    output logic             err
);

    calc_state_t      state;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             exec_ph;
    logic [WIDTH-1:0] stage_res;
    logic             stage_carry;
    logic             stage_ovf;
    logic             stage_err;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_c;
    logic             add_ovf;

`ifdef CALC_MUL_EN
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [4:0]       iter;
`endif

    assign in_ready = (state == IDLE) && !rst;

    // Operand mux: one adder serves ADD, SUB and every MUL partial-product step.
    always_comb begin
        add_a   = a_lat;
        add_b   = b_lat;
        add_cin = 1'b0;
`ifdef CALC_MUL_EN
        if (state == MUL) begin
            add_a   = hi;
            add_b   = a_lat;
            add_cin = 1'b0;
        end else if (op_lat == OP_SUB) begin
            add_b   = ~b_lat;
            add_cin = 1'b1;
        end else begin
            add_b   = b_lat;
            add_cin = 1'b0;
        end
`else
        if (op_lat == OP_SUB) begin
            add_b   = ~b_lat;
            add_cin = 1'b1;
        end else begin
            add_b   = b_lat;
            add_cin = 1'b0;
        end
`endif
    end

    carselec u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_c)
    );

    assign add_ovf = signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);

    // Sequencer FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_lat      <= 2'b00;
            a_lat       <= '0;
            b_lat       <= '0;
            exec_ph     <= 1'b0;
            stage_res   <= '0;
            stage_carry <= 1'b0;
            stage_ovf   <= 1'b0;
            stage_err   <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
`ifdef CALC_MUL_EN
            hi          <= '0;
            lo          <= '0;
            iter        <= 5'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_lat  <= op;
                        a_lat   <= a;
                        b_lat   <= b;
                        exec_ph <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Adder result is staged once so the output register sits off the carry chain.
                    if (!exec_ph) begin
                        exec_ph <= 1'b1;
                        case (op_lat)
                            OP_ADD, OP_SUB: begin
                                stage_res   <= add_sum;
                                stage_carry <= add_c;
                                stage_ovf   <= add_ovf;
                                stage_err   <= 1'b0;
                            end
`ifdef CALC_MUL_EN
                            OP_MUL: begin
                                hi    <= '0;
                                lo    <= b_lat;
                                iter  <= 5'd0;
                                state <= MUL;
                            end
`endif
                            default: begin
                                stage_res   <= '0;
                                stage_carry <= 1'b0;
                                stage_ovf   <= 1'b0;
                                stage_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        result    <= stage_res;
                        carry_out <= stage_carry;
                        ovf       <= stage_ovf;
                        err       <= stage_err;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef CALC_MUL_EN
                MUL: begin
                    if (iter == 5'(MUL_ITERS)) begin
                        result    <= lo;
                        carry_out <= 1'b0;
                        ovf       <= |hi;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (lo[0]) begin
                            {hi, lo} <= {add_c, add_sum, lo[WIDTH-1:1]};
                        end else begin
                            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                        end
                        iter <= iter + 5'd1;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq: arithmetic reference model compared every cycle,
// plus literal expectations per vector. Honours CALC_MUL_EN like the design.
module tb_calc_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        carry_out;
    logic        ovf;
    logic        err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf),
        .err       (err)
    );

    typedef struct packed {
        logic        e;
        logic        o;
        logic        c;
        logic [15:0] r;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        e;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic res_t model_op(input logic [1:0] mop, input logic [15:0] ma, input logic [15:0] mb);
        res_t        rr;
        int          s;
        logic [31:0] p;
        rr = '0;
        case (mop)
            2'b00: begin
                rr.r = ma + mb;
                rr.c = (32'(ma) + 32'(mb)) > 32'd65535;
                s    = int'($signed(ma)) + int'($signed(mb));
                rr.o = (s > 32767) || (s < -32768);
            end
            2'b01: begin
                rr.r = ma - mb;
                rr.c = (ma >= mb);
                s    = int'($signed(ma)) - int'($signed(mb));
                rr.o = (s > 32767) || (s < -32768);
            end
`ifdef CALC_MUL_EN
            2'b10: begin
                p    = 32'(ma) * 32'(mb);
                rr.r = p[15:0];
                rr.o = (p[31:16] != 16'h0000);
            end
`endif
            default: rr.e = 1'b1;
        endcase
        return rr;
    endfunction

    function automatic int model_lat(input logic [1:0] mop);
`ifdef CALC_MUL_EN
        return (mop == 2'b10) ? 18 : 2;
`else
        return 2;
`endif
    endfunction

    bit   cmp_on = 1'b0;
    bit   m_busy = 1'b0;
    bit   m_valid = 1'b0;
    int   m_wait = 0;
    res_t m_pend = '0;
    res_t m_out = '0;

    // Transaction-level model: accept, count down the latency, hold until taken.
    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_out   <= '0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else if (m_busy) begin
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_out   <= m_pend;
            end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_pend <= model_op(op, a, b);
            m_wait <= model_lat(op);
        end
        cmp_on <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        #1;
        if (cmp_on) begin
            check("cmp_out_valid", out_valid, m_valid);
            check("cmp_in_ready", in_ready, !rst && !m_busy);
            check("cmp_result", result, m_out.r);
            check("cmp_carry", carry_out, m_out.c);
            check("cmp_ovf", ovf, m_out.o);
            check("cmp_err", err, m_out.e);
        end
    end

    task automatic run_vec(input vec_t v, input int hold, input bit early);
        int lat;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        op        = v.op;
        a         = v.a;
        b         = v.b;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 2'($urandom_range(3, 0));
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", lat, v.lat);
        check("lit_result", result, v.res);
        check("lit_carry", carry_out, v.c);
        check("lit_ovf", ovf, v.o);
        check("lit_err", err, v.e);
        if (!early) begin
            repeat (hold) @(negedge clk);
            if (hold > 0) begin
                #1;
                check("bp_result_held", result, v.res);
                check("bp_in_ready_low", in_ready, 1'b0);
            end
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_out_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{2'b11, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
`ifdef CALC_MUL_EN
        vecs.push_back('{2'b10, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 18});
        vecs.push_back('{2'b10, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 18});
        vecs.push_back('{2'b10, 16'h0003, 16'h0004, 16'h000C, 1'b0, 1'b0, 1'b0, 18});
        vecs.push_back('{2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 18});
`else
        vecs.push_back('{2'b10, 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1, 2});
`endif

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        check("release_result", result, 16'h0000);

        foreach (vecs[i]) run_vec(vecs[i], 0, 1'b0);
        run_vec(vecs[3], 0, 1'b1);

        // Back-pressure: result held for five cycles with out_ready low.
        run_vec('{2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 2}, 5, 1'b0);

        // Abort an operation in flight with reset.
        @(negedge clk);
`ifdef CALC_MUL_EN
        op = 2'b10;
        a  = 16'h00FF;
        b  = 16'h0101;
`else
        op = 2'b00;
        a  = 16'h0001;
        b  = 16'h0002;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef CALC_MUL_EN
        repeat (7) @(posedge clk);
        @(negedge clk);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        repeat (25) @(negedge clk);
        #1;
        check("abort_no_output", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
